mem_port_arbiter: RTL and testbench

// - Shares the single-port unified SoC RAM between the core's instruction-fetch port (M0) and load/store port (M1).
// - Sits in soc_top between u_core and the RAM.
// - Data port has priority. A starvation counter forces a fetch grant after STARVE_LIMIT consecutive denials.
// - Tracks the owner of the 1-cycle-latency RAM read so the response is steered to the correct master.

---
 rtl/soc_pkg.sv | 13 +
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/soc_pkg.sv
// Shared SoC constants and the response-owner encoding used by the RAM port arbiter.
package soc_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    RSP_IDLE,
    RSP_M0,
    RSP_M1
  } rsp_owner_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares the single-port unified RAM between the instruction-fetch master (M0)
// and the load/store master (M1). M1 has priority. A saturating starvation
// counter hands M0 one grant after STARVE_LIMIT back-to-back denials. The owner
// of each 1-cycle-latency read is remembered so the response reaches the right
// master.
module mem_port_arbiter
  import soc_pkg::*;
#(
  parameter int ADDR_W       = soc_pkg::ADDR_W,
  parameter int DATA_W       = soc_pkg::DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk_i,
  input  logic                rst_n_i,

  input  logic                m0_req_i,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  output logic                m0_gnt_o,
  output logic                m0_rvalid_o,
  output logic [DATA_W-1:0]   m0_rdata_o,

  input  logic                m1_req_i,
  input  logic                m1_we_i,
  input  logic [DATA_W/8-1:0] m1_be_i,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  output logic                m1_gnt_o,
  output logic                m1_rvalid_o,
  output logic [DATA_W-1:0]   m1_rdata_o,

  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  input  logic                mem_ready_i
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  rsp_owner_e r_rsp;
  rsp_owner_e w_rsp_next;
  logic [3:0] r_starve;
  logic       r_we;

  logic       w_ready;
  logic       w_force_m0;
  logic       w_m0_gnt;
  logic       w_m1_gnt;

  // Grants are suppressed while reset is asserted so nothing reaches the RAM
  // even though the masters may already be requesting.
  assign w_ready    = rst_n_i & mem_ready_i;
  assign w_force_m0 = m0_req_i & (r_starve == LIMIT);
  assign w_m0_gnt   = w_ready & (w_force_m0 | (m0_req_i & ~m1_req_i));
  assign w_m1_gnt   = w_ready & ~w_force_m0 & m1_req_i;

  assign m0_gnt_o = w_m0_gnt;
  assign m1_gnt_o = w_m1_gnt;

  // Response owner and write flag advance every cycle; a reset drops any pending response.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rsp <= RSP_IDLE;
      r_we  <= 1'b0;
    end else begin
      r_rsp <= w_rsp_next;
      r_we  <= w_m1_gnt & m1_we_i;
    end
  end

  // Starvation counter: counts consecutive cycles M0 asks but is not served, stalls included.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_starve <= 4'd0;
    end else if (m0_req_i && !w_m0_gnt) begin
      if (r_starve != LIMIT) begin
        r_starve <= r_starve + 4'd1;
      end
    end else begin
      r_starve <= 4'd0;
    end
  end

  // RAM mux, next response owner, and response steering back to the masters.
  always_comb begin
    w_rsp_next  = RSP_IDLE;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    m0_rvalid_o = 1'b0;
    m0_rdata_o  = '0;
    m1_rvalid_o = 1'b0;
    m1_rdata_o  = '0;

    if (w_m0_gnt) begin
      w_rsp_next = RSP_M0;
      mem_req_o  = 1'b1;
      mem_be_o   = '1;
      mem_addr_o = m0_addr_i;
    end else if (w_m1_gnt) begin
      w_rsp_next  = RSP_M1;
      mem_req_o   = 1'b1;
      mem_we_o    = m1_we_i;
      mem_be_o    = m1_be_i;
      mem_addr_o  = m1_addr_i;
      mem_wdata_o = m1_wdata_i;
    end

    case (r_rsp)
      RSP_M0: begin
        m0_rvalid_o = 1'b1;
        m0_rdata_o  = mem_rdata_i;
      end
      RSP_M1: begin
        m1_rvalid_o = 1'b1;
        if (!r_we) begin
          m1_rdata_o = mem_rdata_i;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small byte-enabled RAM model.
module tb_mem_port_arbiter;

  logic        clk_i;
  logic        rst_n_i;
  logic        m0_req_i;
  logic [31:0] m0_addr_i;
  logic        m0_gnt_o;
  logic        m0_rvalid_o;
  logic [31:0] m0_rdata_o;
  logic        m1_req_i;
  logic        m1_we_i;
  logic [3:0]  m1_be_i;
  logic [31:0] m1_addr_i;
  logic [31:0] m1_wdata_i;
  logic        m1_gnt_o;
  logic        m1_rvalid_o;
  logic [31:0] m1_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ready_i;

  int checkCount = 0;
  int failCount  = 0;

  mem_port_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .STARVE_LIMIT(4)
  ) dut (
    .clk_i(clk_i),
    .rst_n_i(rst_n_i),
    .m0_req_i(m0_req_i),
    .m0_addr_i(m0_addr_i),
    .m0_gnt_o(m0_gnt_o),
    .m0_rvalid_o(m0_rvalid_o),
    .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i),
    .m1_we_i(m1_we_i),
    .m1_be_i(m1_be_i),
    .m1_addr_i(m1_addr_i),
    .m1_wdata_i(m1_wdata_i),
    .m1_gnt_o(m1_gnt_o),
    .m1_rvalid_o(m1_rvalid_o),
    .m1_rdata_o(m1_rdata_o),
    .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i),
    .mem_ready_i(mem_ready_i)
  );

  // Free-running 10-unit clock.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // 16-word RAM: byte-enabled writes, read data registered one cycle after the request.
  logic [31:0] ram [16] = '{4: 32'hDEADBEEF, 8: 32'h11223344, default: 32'h0};
  logic [31:0] ramRdata = 32'h0;
  assign mem_rdata_i = ramRdata;

  always @(posedge clk_i) begin
    if (mem_req_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_be_o[b]) ram[mem_addr_o[5:2]][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];
        end
      end
      ramRdata <= ram[mem_addr_o[5:2]];
    end
  end

  typedef struct {
    logic m0Req;
    logic m1Req;
    logic ready;
    logic expM0Gnt;
    logic expM1Gnt;
    logic expM0Rvalid;
    logic expM1Rvalid;
  } vec_t;

  vec_t vecs [19];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Waits for the next rising edge, then drives a fresh set of inputs 1 unit later.
  task automatic applyStimulus(input logic m0Req, input logic [31:0] m0Addr,
                               input logic m1Req, input logic m1We, input logic [3:0] m1Be,
                               input logic [31:0] m1Addr, input logic [31:0] m1Wdata,
                               input logic ready);
    @(posedge clk_i);
    #1;
    m0_req_i    = m0Req;
    m0_addr_i   = m0Addr;
    m1_req_i    = m1Req;
    m1_we_i     = m1We;
    m1_be_i     = m1Be;
    m1_addr_i   = m1Addr;
    m1_wdata_i  = m1Wdata;
    mem_ready_i = ready;
  endtask

  initial begin
    // M1 always reads 0x24 in the table; M0 always fetches 0x10.
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    // Reset held with both masters requesting.
    rst_n_i     = 1'b0;
    m0_req_i    = 1'b1;
    m0_addr_i   = 32'h10;
    m1_req_i    = 1'b1;
    m1_we_i     = 1'b0;
    m1_be_i     = 4'hF;
    m1_addr_i   = 32'h24;
    m1_wdata_i  = 32'h0;
    mem_ready_i = 1'b1;

    for (int c = 0; c < 2; c++) begin
      @(posedge clk_i);
      #2;
      checkOutput("rst m0_gnt", 32'(m0_gnt_o), 32'h0);
      checkOutput("rst m1_gnt", 32'(m1_gnt_o), 32'h0);
      checkOutput("rst mem_req", 32'(mem_req_o), 32'h0);
      checkOutput("rst m0_rvalid", 32'(m0_rvalid_o), 32'h0);
      checkOutput("rst m1_rvalid", 32'(m1_rvalid_o), 32'h0);
      checkOutput("rst mem_addr", mem_addr_o, 32'h0);
    end

    // Release: M1 takes the first grant.
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    #1;
    checkOutput("release m1_gnt", 32'(m1_gnt_o), 32'h1);
    checkOutput("release m0_gnt", 32'(m0_gnt_o), 32'h0);
    checkOutput("release mem_addr", mem_addr_o, 32'h24);

    applyStimulus(1'b0, 32'h10, 1'b0, 1'b0, 4'hF, 32'h24, 32'h0, 1'b1);
    #1;
    checkOutput("release m1_rvalid", 32'(m1_rvalid_o), 32'h1);
    checkOutput("release m0_rvalid", 32'(m0_rvalid_o), 32'h0);

    // Priority, starvation and stall vectors.
    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i].m0Req, 32'h10, vecs[i].m1Req, 1'b0, 4'hF, 32'h24, 32'h0, vecs[i].ready);
      #1;
      checkOutput($sformatf("vec%0d m0_gnt", i), 32'(m0_gnt_o), 32'(vecs[i].expM0Gnt));
      checkOutput($sformatf("vec%0d m1_gnt", i), 32'(m1_gnt_o), 32'(vecs[i].expM1Gnt));
      checkOutput($sformatf("vec%0d m0_rvalid", i), 32'(m0_rvalid_o), 32'(vecs[i].expM0Rvalid));
      checkOutput($sformatf("vec%0d m1_rvalid", i), 32'(m1_rvalid_o), 32'(vecs[i].expM1Rvalid));
      checkOutput($sformatf("vec%0d mem_req", i), 32'(mem_req_o), 32'(vecs[i].expM0Gnt | vecs[i].expM1Gnt));
    end

    // Fetch of 0x10 returns 0xDEADBEEF the following cycle.
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 32'hA5A5A5A5, 1'b1);
    #1;
    checkOutput("fetch m0_gnt", 32'(m0_gnt_o), 32'h1);
    checkOutput("fetch mem_addr", mem_addr_o, 32'h10);
    checkOutput("fetch mem_be", 32'(mem_be_o), 32'hF);
    checkOutput("fetch mem_we", 32'(mem_we_o), 32'h0);
    checkOutput("fetch mem_wdata", mem_wdata_o, 32'h0);
    applyStimulus(1'b0, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    #1;
    checkOutput("fetch m0_rvalid", 32'(m0_rvalid_o), 32'h1);
    checkOutput("fetch m0_rdata", m0_rdata_o, 32'hDEADBEEF);
    checkOutput("fetch m1_rdata", m1_rdata_o, 32'h0);

    // Byte write of 0x55 to 0x20, then read back merged word.
    applyStimulus(1'b0, 32'h10, 1'b1, 1'b1, 4'b0001, 32'h20, 32'h00000055, 1'b1);
    #1;
    checkOutput("wr m1_gnt", 32'(m1_gnt_o), 32'h1);
    checkOutput("wr mem_we", 32'(mem_we_o), 32'h1);
    checkOutput("wr mem_be", 32'(mem_be_o), 32'h1);
    checkOutput("wr mem_addr", mem_addr_o, 32'h20);
    checkOutput("wr mem_wdata", mem_wdata_o, 32'h55);
    applyStimulus(1'b0, 32'h10, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0, 1'b1);
    #1;
    checkOutput("wrack m1_rvalid", 32'(m1_rvalid_o), 32'h1);
    checkOutput("wrack m1_rdata", m1_rdata_o, 32'h0);
    checkOutput("rd m1_gnt", 32'(m1_gnt_o), 32'h1);
    checkOutput("wrack m0_rdata", m0_rdata_o, 32'h0);
    applyStimulus(1'b0, 32'h10, 1'b0, 1'b0, 4'hF, 32'h20, 32'h0, 1'b1);
    #1;
    checkOutput("rd m1_rvalid", 32'(m1_rvalid_o), 32'h1);
    checkOutput("rd m1_rdata", m1_rdata_o, 32'h11223355);
    checkOutput("rd m0_rvalid", 32'(m0_rvalid_o), 32'h0);

    // Reset asserted the cycle after an M1 read grant drops the response.
    applyStimulus(1'b0, 32'h10, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0, 1'b1);
    #1;
    checkOutput("midrst m1_gnt", 32'(m1_gnt_o), 32'h1);
    @(posedge clk_i);
    #1;
    rst_n_i  = 1'b0;
    m0_req_i = 1'b1;
    #1;
    checkOutput("midrst m1_rvalid", 32'(m1_rvalid_o), 32'h0);
    checkOutput("midrst m1_rdata", m1_rdata_o, 32'h0);
    checkOutput("midrst mem_req", 32'(mem_req_o), 32'h0);
    checkOutput("midrst m0_gnt", 32'(m0_gnt_o), 32'h0);
    @(posedge clk_i);
    #1;
    rst_n_i  = 1'b1;
    m0_req_i = 1'b0;
    m1_req_i = 1'b0;
    #1;
    checkOutput("postrst m1_rvalid", 32'(m1_rvalid_o), 32'h0);
    applyStimulus(1'b0, 32'h10, 1'b0, 1'b0, 4'hF, 32'h20, 32'h0, 1'b1);
    #1;
    checkOutput("postrst2 m1_rvalid", 32'(m1_rvalid_o), 32'h0);
    checkOutput("postrst2 m0_rvalid", 32'(m0_rvalid_o), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
